// File: rtl/exec_unit_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared types for the exec_unit execute stage: the ARM data-processing opcode
// encoding, the stage FSM states, the bit positions of N/Z/C/V inside the
// 4-bit flags output, and a packed struct for the internal flag register.
// -----------------------------------------------------------------------------
package exec_pkg;

    // ARM data-processing opcode, inst[24:21].
    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_EOR = 4'd1,
        OP_SUB = 4'd2,
        OP_RSB = 4'd3,
        OP_ADD = 4'd4,
        OP_ADC = 4'd5,
        OP_SBC = 4'd6,
        OP_RSC = 4'd7,
        OP_TST = 4'd8,
        OP_TEQ = 4'd9,
        OP_CMP = 4'd10,
        OP_CMN = 4'd11,
        OP_ORR = 4'd12,
        OP_MOV = 4'd13,
        OP_BIC = 4'd14,
        OP_MVN = 4'd15
    } exec_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exec_state_e;

    // Bit positions inside the {N,Z,C,V} flags vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } exec_flags_t;

endpackage

// File: rtl/exec_unit_mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Computes the low WIDTH bits of a*b + acc.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset; aborts a running multiply
//   start    in   load operands (one-cycle pulse)
//   a        in   multiplicand
//   b        in   multiplier
//   acc      in   addend (zero for plain MUL)
//   done     out  high during the final step; `product` is the final value then
//   product  out  accumulator after the current step (combinational)
//
// Timing: start sampled at edge k, steps happen on edges k+1 .. k+WIDTH and
// `done` is high in the cycle before edge k+WIDTH, so the caller can register
// `product` on that very edge.
// -----------------------------------------------------------------------------
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] accum_q;

    // The final step's sum is exposed directly so no extra cycle is spent
    // registering it here before the caller captures it.
    assign product = accum_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = busy_q && (count_q == CW'(WIDTH - 1));

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            count_q <= '0;
        end else if (start) begin
            busy_q  <= 1'b1;
            count_q <= '0;
        end else if (busy_q) begin
            count_q <= count_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    // NOTE: the operand/accumulator registers carry no reset; they are always
    // reloaded by `start` before being read, and busy_q alone gates validity.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            accum_q  <= acc;
        end else if (busy_q) begin
            accum_q  <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit
// Handshaked execute stage: single-cycle ARM data-processing ALU plus an
// optional iterative MUL/MLA. Holds the registered result and the
// architectural NZCV flag register.
//
// Build option: define EXEC_MUL_EN to build the multiplier and MUL state.
// Without it an is_mul request completes in one cycle with result 0,
// write_result 0 and flags untouched.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready combinational)
//   op                data-processing opcode (ignored when is_mul)
//   is_mul, mul_acc   multiply request; mul_acc selects MLA
//   set_flags         S bit
//   a, b, acc         Rn/multiplicand, shifter output/multiplier, MLA addend
//   shifter_carry     carry used for C on logical ops
//   out_valid/out_ready output handshake
//   result            registered result
//   write_result      0 for TST/TEQ/CMP/CMN, 1 otherwise
//   flags             registered {N,Z,C,V}
// -----------------------------------------------------------------------------
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             is_mul,
    input  logic             mul_acc,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  logic             shifter_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             write_result,
    output logic [3:0]       flags
);

`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    exec_state_e      state_q, state_d;
    exec_flags_t      flags_q;
    exec_op_e         op_e;
    logic             accept;
    logic             mul_go;
    logic             mul_set_flags_q;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] add_x, add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] alu_result;
    logic             alu_logic;
    logic             alu_write;
    exec_flags_t      alu_flags;

    assign op_e     = exec_op_e'(op);
    assign in_ready = !reset && (state_q == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign mul_go   = accept && is_mul && MUL_EN;

    assign flags[FLAG_N] = flags_q.n;
    assign flags[FLAG_Z] = flags_q.z;
    assign flags[FLAG_C] = flags_q.c;
    assign flags[FLAG_V] = flags_q.v;

    // Every arithmetic op is x + y + cin: subtracts invert the subtrahend,
    // so the adder carry-out is directly C = NOT borrow.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_cin = 1'b0;
        case (op_e)
            OP_SUB, OP_CMP: begin add_y = ~b; add_cin = 1'b1; end
            OP_RSB:         begin add_x = b;  add_y = ~a; add_cin = 1'b1; end
            OP_ADC:         begin add_cin = flags_q.c; end
            OP_SBC:         begin add_y = ~b; add_cin = flags_q.c; end
            OP_RSC:         begin add_x = b;  add_y = ~a; add_cin = flags_q.c; end
            default:        ;
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

    always_comb begin
        alu_result = add_sum[WIDTH-1:0];
        alu_logic  = 1'b1;
        case (op_e)
            OP_AND, OP_TST: alu_result = a & b;
            OP_EOR, OP_TEQ: alu_result = a ^ b;
            OP_ORR:         alu_result = a | b;
            OP_MOV:         alu_result = b;
            OP_BIC:         alu_result = a & ~b;
            OP_MVN:         alu_result = ~b;
            default:        alu_logic  = 1'b0;
        endcase

        alu_flags   = flags_q;
        alu_flags.n = alu_result[WIDTH-1];
        alu_flags.z = (alu_result == '0);
        if (alu_logic) begin
            alu_flags.c = shifter_carry;
        end else begin
            alu_flags.c = add_sum[WIDTH];
            // Signed overflow: both adder inputs agree in sign, sum does not.
            alu_flags.v = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                          (alu_result[WIDTH-1] != add_x[WIDTH-1]);
        end
    end

    assign alu_write = !(op_e inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_go)   state_d = ST_MUL;
            ST_MUL:  if (mul_done) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            out_valid       <= 1'b0;
            result          <= '0;
            write_result    <= 1'b0;
            flags_q         <= '0;
            mul_set_flags_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mul_go) begin
                mul_set_flags_q <= set_flags;
            end

            if (accept && !mul_go) begin
                out_valid <= 1'b1;
                if (is_mul) begin
                    // Multiplier not built: complete as a no-op.
                    result       <= '0;
                    write_result <= 1'b0;
                end else begin
                    result       <= alu_result;
                    write_result <= alu_write;
                    if (set_flags) begin
                        flags_q <= alu_flags;
                    end
                end
            end else if (mul_done) begin
                out_valid    <= 1'b1;
                result       <= mul_product;
                write_result <= 1'b1;
                if (mul_set_flags_q) begin
                    flags_q.n <= mul_product[WIDTH-1];
                    flags_q.z <= (mul_product == '0);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef EXEC_MUL_EN
    logic [WIDTH-1:0] mul_addend;
    logic             mul_iter_done;

    assign mul_addend = mul_acc ? acc : '0;
    assign mul_done   = mul_iter_done && (state_q == ST_MUL);

    mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_go),
        .a       (a),
        .b       (b),
        .acc     (mul_addend),
        .done    (mul_iter_done),
        .product (mul_product)
    );
`else
    logic unused_mul_inputs;

    assign unused_mul_inputs = ^{acc, mul_acc};
    assign mul_done          = 1'b0;
    assign mul_product       = '0;
`endif

endmodule

// File: tb/tb_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_unit
// Self-checking bench for exec_unit (WIDTH = 32). Stimulus pushes expected
// responses from a behavioural model into a queue; a monitor pops and compares
// whenever an output transfer happens. Follows EXEC_MUL_EN like the design.
// -----------------------------------------------------------------------------
module tb_exec_unit;

    localparam int W = 32;
`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]   op;
        bit           is_mul;
        bit           mla;
        bit           s;
        bit           shc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] acc;
    } txn_t;

    typedef struct {
        logic [W-1:0] result;
        logic         wr;
        logic [3:0]   flags;
        int           due;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic         is_mul;
    logic         mul_acc;
    logic         set_flags;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] acc;
    logic         shifter_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         write_result;
    logic [3:0]   flags;

    exec_unit #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op            (op),
        .is_mul        (is_mul),
        .mul_acc       (mul_acc),
        .set_flags     (set_flags),
        .a             (a),
        .b             (b),
        .acc           (acc),
        .shifter_carry (shifter_carry),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .write_result  (write_result),
        .flags         (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    logic [3:0] flags_m = 4'b0000;   // model NZCV
    int   ready_mode = 0;            // 0 high, 1 low, 2 random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, wanted %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain integer arithmetic on the ARM rules.
    task automatic model(input txn_t t, output exp_t e);
        logic [W-1:0]      xa, ya, r;
        longint unsigned   x, y, full;
        longint            sx, sy, sres;
        longint unsigned   ci, bo;
        bit                arith;
        logic [3:0]        nf;
        nf    = flags_m;
        ci    = flags_m[1] ? 1 : 0;
        bo    = 1 - ci;
        arith = 1'b1;
        full  = 0;
        sres  = 0;
        e.wr  = 1'b1;
        if (t.is_mul) begin
            if (MUL_EN) begin
                x    = t.a;
                y    = t.b;
                full = x * y + (t.mla ? longint'(t.acc) : 0);
                r    = full[W-1:0];
                if (t.s) begin nf[3] = r[W-1]; nf[2] = (r == 0); end
            end else begin
                r    = '0;
                e.wr = 1'b0;
            end
        end else begin
            if (t.op == 4'd3 || t.op == 4'd7) begin xa = t.b; ya = t.a; end
            else begin xa = t.a; ya = t.b; end
            x = xa; y = ya; sx = $signed(xa); sy = $signed(ya);
            r = '0;
            case (t.op)
                4'd4, 4'd11:       begin full = x + y;      sres = sx + sy; end
                4'd5:              begin full = x + y + ci; sres = sx + sy + longint'(ci); end
                4'd2, 4'd3, 4'd10: begin full = x - y;      sres = sx - sy; end
                4'd6, 4'd7:        begin full = x - y - bo; sres = sx - sy - longint'(bo); end
                default: arith = 1'b0;
            endcase
            case (t.op)
                4'd0, 4'd8:  r = t.a & t.b;
                4'd1, 4'd9:  r = t.a ^ t.b;
                4'd12:       r = t.a | t.b;
                4'd13:       r = t.b;
                4'd14:       r = t.a & ~t.b;
                4'd15:       r = ~t.b;
                default:     r = full[W-1:0];
            endcase
            e.wr = !(t.op >= 4'd8 && t.op <= 4'd11);
            if (t.s) begin
                nf[3] = r[W-1];
                nf[2] = (r == 0);
                if (arith) begin
                    if (t.op == 4'd4 || t.op == 4'd11 || t.op == 4'd5) nf[1] = full[W];
                    else if (t.op == 4'd6 || t.op == 4'd7) nf[1] = (x >= y + bo);
                    else nf[1] = (x >= y);
                    nf[0] = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
                end else begin
                    nf[1] = t.shc;
                end
            end
        end
        flags_m  = nf;
        e.result = r;
        e.flags  = nf;
        e.due    = 0;
    endtask

    // Present one op, wait (bounded) for acceptance, record the expectation.
    task automatic issue(input txn_t t, output int waited);
        exp_t e;
        op = t.op; is_mul = t.is_mul; mul_acc = t.mla; set_flags = t.s;
        a = t.a; b = t.b; acc = t.acc; shifter_carry = t.shc;
        in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        check("issue_accept", in_ready, 1);
        if (in_ready) begin
            model(t, e);
            e.due = cyc + 1 + ((t.is_mul && MUL_EN) ? W : 0);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic txn_t dp(input logic [3:0] o, input bit s,
                                input logic [W-1:0] a_, input logic [W-1:0] b_,
                                input bit shc_);
        txn_t t;
        t.op = o; t.is_mul = 1'b0; t.mla = 1'b0; t.s = s; t.shc = shc_;
        t.a = a_; t.b = b_; t.acc = '0;
        return t;
    endfunction

    function automatic txn_t mulop(input bit mla_, input bit s,
                                   input logic [W-1:0] a_, input logic [W-1:0] b_,
                                   input logic [W-1:0] acc_);
        txn_t t;
        t.op = 4'($urandom_range(0, 15)); t.is_mul = 1'b1; t.mla = mla_; t.s = s;
        t.shc = 1'b0; t.a = a_; t.b = b_; t.acc = acc_;
        return t;
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // out_ready driver, applied a little after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: latency on first presentation, stability while stalled,
    // scoreboard compare on each transfer.
    initial begin : monitor
        logic [W+4:0] held;
        logic [W+4:0] now_v;
        exp_t         e;
        bit           holding;
        bit           fresh;
        holding = 1'b0;
        fresh   = 1'b1;
        forever begin
            @(negedge clk);
            now_v = {result, write_result, flags};
            if (reset) begin
                fresh   = 1'b1;
                holding = 1'b0;
            end else if (out_valid) begin
                if (fresh) begin
                    if (sb.size() == 0) check("unexpected_output", out_valid, 0);
                    else check("latency", cyc, sb[0].due);
                    fresh = 1'b0;
                end
                if (holding) check("hold_stable", now_v, held);
                if (out_ready) begin
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("scoreboard", now_v, {e.result, e.wr, e.flags});
                    end
                    fresh   = 1'b1;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = now_v;
                end
            end
        end
    end

    initial begin : stim
        txn_t t;
        int   w;
        int   hi;
        reset = 1'b1; in_valid = 1'b0; op = '0; is_mul = 1'b0; mul_acc = 1'b0;
        set_flags = 1'b0; a = '0; b = '0; acc = '0; shifter_carry = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_write_result", write_result, 0);
        check("rst_flags", flags, 4'b0000);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADDS 1+1
        issue(dp(4'd4, 1, 32'd1, 32'd1, 0), w);
        @(negedge clk);
        check("adds_1_1_result", result, 32'd2);
        check("adds_1_1_flags", flags, 4'b0000);
        check("adds_1_1_write", write_result, 1);
        @(posedge clk); #1;

        // Signed overflow, then equal subtract
        issue(dp(4'd4, 1, 32'h7FFF_FFFF, 32'd1, 0), w);
        @(negedge clk);
        check("adds_ovf_flags", flags, 4'b1001);
        @(posedge clk); #1;
        issue(dp(4'd2, 1, 32'd5, 32'd5, 0), w);
        @(negedge clk);
        check("subs_eq_flags", flags, 4'b0110);
        @(posedge clk); #1;

        // Carry out, then ADC back-to-back uses it
        issue(dp(4'd4, 1, 32'hFFFF_FFFF, 32'd1, 0), w);
        issue(dp(4'd5, 0, 32'd0, 32'd0, 0), w);
        @(negedge clk);
        check("adc_carry_in", result, 32'd1);
        @(posedge clk); #1;

        // CMP with backpressure
        issue(dp(4'd10, 1, 32'd3, 32'd3, 0), w);
        ready_mode = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("cmp_write_result", write_result, 0);
                check("cmp_z", flags[2], 1);
            end
            check("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        ready_mode = 0;
        issue(dp(4'd13, 1, 32'd0, 32'd0, 1), w);
        check("accept_on_ready_rise", w, 0);

        // MLA with C preset
        issue(dp(4'd10, 1, 32'd3, 32'd3, 0), w);
        issue(mulop(1, 1, 32'd3, 32'd5, 32'd7), w);
`ifdef EXEC_MUL_EN
        hi = 0;
        repeat (W) begin
            @(negedge clk);
            if (in_ready) hi++;
        end
        check("mul_in_ready_low", hi, 0);
        @(negedge clk);
        check("mla_result", result, 32'd22);
        check("mla_flags", flags, 4'b0010);
`else
        @(negedge clk);
        check("mul_off_result", result, 32'd0);
        check("mul_off_write", write_result, 0);
        check("mul_off_flags", flags, 4'b0110);
`endif
        @(posedge clk); #1;

        // Reset in the middle of a multiply
        issue(mulop(0, 1, 32'd9, 32'd9, 32'd0), w);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        flags_m = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("mul_abort_out_valid", out_valid, 0);
        check("mul_abort_flags", flags, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Randomised traffic with random backpressure
        ready_mode = 2;
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) == 0)
                t = mulop($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          rnd_val(), rnd_val(), rnd_val());
            else
                t = dp(4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                       rnd_val(), rnd_val(), $urandom_range(0, 1) == 1);
            issue(t, w);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        // Drain
        ready_mode = 0;
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised, handshaked execute stage for the iProcess datapath. Consumes a decoded data-processing or multiply operation with operands already through the barrel shifter. Produces a registered result and maintains the architectural NZCV flag register internally. Single-cycle for all ARM data-processing opcodes; iterative multi-cycle for MUL/MLA.

## Interface
- `WIDTH`, 32: datapath width in bits; must be ≥ 8.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: stage can accept; transfer on `in_valid & in_ready`.
- `op` in 4: ARM data-processing opcode `inst[24:21]`: AND=0, EOR=1, SUB=2, RSB=3, ADD=4, ADC=5, SBC=6, RSC=7, TST=8, TEQ=9, CMP=10, CMN=11, ORR=12, MOV=13, BIC=14, MVN=15.
- `is_mul` in 1: multiply request; `op` is ignored.
- `mul_acc` in 1: with `is_mul`, MLA; otherwise MUL.
- `set_flags` in 1: S bit; update NZCV.
- `a` in WIDTH: Rn, or multiplicand.
- `b` in WIDTH: shifter output, or multiplier.
- `acc` in WIDTH: MLA addend.
- `shifter_carry` in 1: shifter carry-out, used for C on logical ops.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer takes the result.
- `result` out WIDTH: registered result.
- `write_result` out 1: 0 for TST/TEQ/CMP/CMN; 1 otherwise.
- `flags` out 4: registered NZCV as {N,Z,C,V}.

## Operation
- FSM states:
  - IDLE: `in_ready = !reset & (!out_valid | out_ready)`. A non-multiply accept loads `result`, `write_result`, and flags if `set_flags`. A multiply accept goes to MUL.
  - MUL: `in_ready = 0`. Runs WIDTH shift-add steps, then loads `result` and sets `out_valid`. Returns to IDLE.
- `out_valid` clears on `out_valid & out_ready` unless a new result loads on the same edge. Back-to-back operation at full rate is required.
- Arithmetic is modulo 2^WIDTH.
  - ADC/SBC/RSC use the `flags` C as it stands at the accept edge. This already reflects every earlier operation, because flags load with the result.
  - Subtracts set C = NOT borrow.
  - V is signed overflow for add and subtract.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN) with S: N and Z from the result, C = `shifter_carry`, V unchanged.
- Multiply: `result` = low WIDTH bits of a·b (+acc for MLA). With S, N and Z update; C and V are unchanged.
- `set_flags = 0`: flags are untouched.
- Reset state: IDLE; `out_valid` = 0, `result` = 0, `write_result` = 0, `flags` = 0000. Reset during MUL aborts with no result.

## Timing
- Non-multiply: accept at edge k gives `out_valid` and `result` valid after edge k (latency 1).
- Multiply: accept at edge k gives `out_valid` after edge k+WIDTH. `in_ready` is low for edges k+1 … k+WIDTH.
- Backpressure: `result`, `flags` and `write_result` stay stable while `out_valid & !out_ready`.
- `in_ready` is combinational from state, `out_valid`, `out_ready` and `reset`. No other output is combinational.

## Configuration
- `EXEC_MUL_EN` defined: multiplier and MUL state built.
- `EXEC_MUL_EN` undefined: MUL state and multiplier removed. An `is_mul` request is accepted as a single-cycle op with `result` = 0, `write_result` = 0, flags untouched.

## Structure
- Package `exec_pkg`:
  - opcode enum `exec_op_e`
  - FSM enum `exec_state_e`
  - flag index constants `FLAG_N/Z/C/V`
  - flag struct
- Sub-module `mul_iter`, WIDTH-parametrised: one bit per cycle, `start`/`done` interface. Instantiated only under `EXEC_MUL_EN`.

## Test plan
1. ADD with S, a=1, b=1 → `result` = 2 one cycle later, `flags` = 0000, `write_result` = 1.
2. ADDS 0x7FFFFFFF+1 → 0x80000000, NZCV = 1001. Then SUBS 5−5 → 0, NZCV = 0110.
3. ADDS 0xFFFFFFFF+1 → 0, NZCV = 0110. Then ADC 0+0 back-to-back → 1.
4. CMP 3,3 → `write_result` = 0, Z = 1. Hold `out_ready` low 3 cycles → `result` stable and `in_ready` = 0. Next op accepted on the cycle `out_ready` rises.
5. MLA a=3, b=5, acc=7, S with C=1 preset → 22 after 32 cycles, NZCV = 0010, `in_ready` low throughout.
6. Reset on cycle 10 of MUL → next cycle `out_valid` = 0, `flags` = 0000. `in_ready` = 1 on the first cycle after reset deasserts.
